// File: rtl/output_port_allocator.sv
// Output port allocator and downstream credit tracker for one crossbar output.
// Round-robin arbitration among five inputs, wormhole lock from header to tail,
// and per-flit gating on downstream credits.
// Optional feature macro: OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN adds a sticky
// o_credit_err flag for credits returned while the counter is already full.
module output_port_allocator #(
    parameter int unsigned CREDIT_MAX   = 3,
    parameter int unsigned CREDIT_WIDTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              i_req,
    input  logic [4:0]              i_tail,
    input  logic                    i_credit_in,
    output logic [4:0]              o_grant,
    output logic [4:0]              o_sel,
    output logic                    o_valid_out,
    output logic [CREDIT_WIDTH-1:0] o_credit_count
`ifdef OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN
    ,
    output logic                    o_credit_err
`endif
);

    localparam logic [CREDIT_WIDTH-1:0] CreditMax = CREDIT_WIDTH'(CREDIT_MAX);
    localparam logic [CREDIT_WIDTH-1:0] CreditOne = CREDIT_WIDTH'(1);

    typedef enum logic {StIdle, StLocked} state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [4:0]              r_sel;
    logic [4:0]              w_sel_nxt;
    logic [2:0]              r_rr_ptr;
    logic [2:0]              w_rr_ptr_nxt;
    logic [CREDIT_WIDTH-1:0] r_credit;
    logic [CREDIT_WIDTH-1:0] w_credit_nxt;

    logic [4:0]              w_rr_winner;
    logic [2:0]              w_owner_idx;
    logic [2:0]              w_owner_idx_inc;
    logic                    w_owner_req;
    logic                    w_owner_tail;
    logic                    w_cnt_zero;
    logic                    w_cnt_full;
    logic                    w_transfer;

    // sel is one-hot while locked, so masking picks out the owner's bits directly
    assign w_owner_req  = |(i_req & r_sel);
    assign w_owner_tail = |(i_tail & r_sel);
    assign w_cnt_zero   = (r_credit == '0);
    assign w_cnt_full   = (r_credit == CreditMax);
    assign w_transfer   = (r_state == StLocked) && w_owner_req && !w_cnt_zero;

    // Round-robin pick: first requesting input scanning from r_rr_ptr upward, mod 5
    always_comb begin
        logic       v_found;
        logic [3:0] v_sum;
        logic [2:0] v_idx;
        w_rr_winner = '0;
        v_found     = 1'b0;
        v_sum       = '0;
        v_idx       = '0;
        for (int k = 0; k < 5; k++) begin
            v_sum = {1'b0, r_rr_ptr} + 4'(k);
            v_idx = (v_sum >= 4'd5) ? 3'(v_sum - 4'd5) : v_sum[2:0];
            if (!v_found && i_req[v_idx]) begin
                w_rr_winner[v_idx] = 1'b1;
                v_found            = 1'b1;
            end
        end
    end

    // Encode the one-hot select into the owner index and its round-robin successor
    always_comb begin
        w_owner_idx = '0;
        for (int k = 0; k < 5; k++) begin
            if (r_sel[k]) begin
                w_owner_idx = 3'(k);
            end
        end
        w_owner_idx_inc = (w_owner_idx == 3'd4) ? 3'd0 : w_owner_idx + 3'd1;
    end

    // Lock FSM: next state, select and round-robin pointer, plus transfer strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        o_grant      = '0;
        o_valid_out  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|i_req) begin
                    w_state_nxt = StLocked;
                    w_sel_nxt   = w_rr_winner;
                end
            end
            StLocked: begin
                if (w_transfer) begin
                    o_grant     = r_sel;
                    o_valid_out = 1'b1;
                    if (w_owner_tail) begin
                        w_state_nxt  = StIdle;
                        w_sel_nxt    = '0;
                        w_rr_ptr_nxt = w_owner_idx_inc;
                    end
                end
            end
        endcase
    end

    // Credit counter: a transfer consumes a slot, credit_in returns one; both cancel
    always_comb begin
        w_credit_nxt = r_credit;
        if (w_transfer && !i_credit_in) begin
            w_credit_nxt = r_credit - CreditOne;
        end else if (i_credit_in && !w_transfer && !w_cnt_full) begin
            w_credit_nxt = r_credit + CreditOne;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_credit <= CreditMax;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign o_sel          = r_sel;
    assign o_credit_count = r_credit;

`ifdef OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN
    logic w_credit_ovf;
    logic r_credit_err;

    // A returned credit with no room to store it means downstream over-counted
    assign w_credit_ovf = i_credit_in && !w_transfer && w_cnt_full;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_credit_err <= 1'b0;
        end else if (w_credit_ovf) begin
            r_credit_err <= 1'b1;
        end
    end

    assign o_credit_err = r_credit_err;
`endif

endmodule

// File: tb/tb_output_port_allocator.sv
// Self-checking bench for output_port_allocator: directed scenarios followed by
// randomized traffic, all checked against a packet-level reference model.
module tb_output_port_allocator;

    localparam int CreditMax = 3;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic [4:0] tail;
    logic       credit_in;
    logic [4:0] grant;
    logic [4:0] sel;
    logic       valid_out;
    logic [1:0] credit_count;
`ifdef OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN
    logic       credit_err;
`endif

    output_port_allocator #(
        .CREDIT_MAX   (3),
        .CREDIT_WIDTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (req),
        .i_tail         (tail),
        .i_credit_in    (credit_in),
        .o_grant        (grant),
        .o_sel          (sel),
        .o_valid_out    (valid_out),
        .o_credit_count (credit_count)
`ifdef OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN
        ,
        .o_credit_err   (credit_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owning input (-1 when no packet in flight), next priority
    // input, available downstream slots, and the sticky overflow flag.
    int m_owner = -1;
    int m_rr    = 0;
    int m_cred  = CreditMax;
    int m_err   = 0;
    int m_known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check the outputs the
    // model predicts for this cycle, then advance the model across the rising edge.
    task automatic cycle(input logic rst_n, input logic [4:0] rq, input logic [4:0] tl,
                         input logic ci);
        logic [4:0] e_sel;
        logic       xfer;
        bit         found;
        int         c;
        @(negedge clk);
        reset     = rst_n;
        req       = rq;
        tail      = tl;
        credit_in = ci;
        #1;
        e_sel = '0;
        if (m_owner >= 0) e_sel[m_owner] = 1'b1;
        xfer = (m_owner >= 0) && rq[m_owner] && (m_cred > 0);
        if (rst_n && m_known != 0) begin
            chk("sel", 32'(sel), 32'(e_sel));
            chk("grant", 32'(grant), xfer ? 32'(e_sel) : 32'd0);
            chk("valid_out", 32'(valid_out), 32'(xfer));
            chk("credit_count", 32'(credit_count), 32'(m_cred));
`ifdef OUTPUT_PORT_ALLOCATOR_CREDIT_ERR_EN
            chk("credit_err", 32'(credit_err), 32'(m_err));
`endif
        end
        if (!rst_n) begin
            m_owner = -1;
            m_rr    = 0;
            m_cred  = CreditMax;
            m_err   = 0;
            m_known = 1;
        end else begin
            if (xfer && !ci) m_cred--;
            else if (ci && !xfer) begin
                if (m_cred < CreditMax) m_cred++;
                else m_err = 1;
            end
            if (m_owner < 0) begin
                found = 0;
                for (int k = 0; k < 5; k++) begin
                    c = (m_rr + k) % 5;
                    if (!found && rq[c]) begin
                        m_owner = c;
                        found   = 1;
                    end
                end
            end else if (xfer && tl[m_owner]) begin
                m_rr    = (m_owner + 1) % 5;
                m_owner = -1;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        req       = '0;
        tail      = '0;
        credit_in = 1'b0;

        // Reset, then an idle cycle checks the reset state
        cycle(1'b0, 5'b00000, 5'b00000, 1'b0);
        cycle(1'b0, 5'b00000, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00000, 5'b00000, 1'b0);

        // West requests a long packet with no credit returns: 3 grants then stall
        cycle(1'b1, 5'b00100, 5'b00000, 1'b0);
        #1 chk("west_locked", 32'(sel), 32'h04);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'b00100, 5'b00000, 1'b0);
        #1 chk("credits_drained", 32'(credit_count), 32'd0);
        cycle(1'b1, 5'b00100, 5'b00000, 1'b0);
        // Credit return with tail at head, then tail goes out, then release
        cycle(1'b1, 5'b00100, 5'b00100, 1'b1);
        cycle(1'b1, 5'b00100, 5'b00100, 1'b0);
        cycle(1'b1, 5'b11111, 5'b11111, 1'b1);
        #1 chk("rr_after_west", 32'(sel), 32'h08);
        cycle(1'b1, 5'b11111, 5'b11111, 1'b1);
        cycle(1'b1, 5'b00000, 5'b00000, 1'b1);

        // All inputs send single-flit packets: served L,S,W,E,N,L two cycles apart
        cycle(1'b0, 5'b00000, 5'b00000, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 5'b11111, 5'b11111, 1'b1);

        // Owner drops its request mid-packet while North waits
        cycle(1'b0, 5'b00000, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00001, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00001, 5'b00000, 1'b0);
        cycle(1'b1, 5'b10000, 5'b00000, 1'b0);
        cycle(1'b1, 5'b10000, 5'b00000, 1'b0);
        #1 chk("owner_held", 32'(sel), 32'h01);
        cycle(1'b1, 5'b10001, 5'b00001, 1'b0);
        cycle(1'b1, 5'b10000, 5'b00000, 1'b0);
        #1 chk("north_after_tail", 32'(sel), 32'h10);

        // Transfer and credit return together at count 2, then reset while locked
        cycle(1'b0, 5'b00000, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00010, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00010, 5'b00000, 1'b0);
        cycle(1'b1, 5'b00010, 5'b00000, 1'b1);
        #1 chk("xfer_and_credit", 32'(credit_count), 32'd2);
        cycle(1'b0, 5'b00010, 5'b00000, 1'b0);
        #1 chk("reset_locked_sel", 32'(sel), 32'h00);
        chk("reset_locked_cred", 32'(credit_count), 32'd3);
        cycle(1'b1, 5'b00000, 5'b00000, 1'b0);

        // Credit returned with the counter full while idle
        cycle(1'b1, 5'b00000, 5'b00000, 1'b1);
        #1 chk("saturate", 32'(credit_count), 32'd3);
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'b00000, 5'b00000, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            logic [4:0] rq;
            logic [4:0] tl;
            rq = 5'($urandom);
            if ($urandom_range(0, 3) == 0) rq = '0;
            tl = 5'($urandom) & 5'($urandom);
            cycle(($urandom_range(0, 60) != 0), rq, tl, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
